ext_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle immediate extender, for the pipelined datapath. Performs immediate extension (sign, zero, LUI-high) and load-data extraction/extension (byte, halfword, full word) under a valid/ready handshake. Output goes through a 2-entry skid buffer so the block can sit between the MEM and WB stages and honour back-pressure without a combinational ready path.

---
 rtl/ext_pkg.sv | 15 +
 rtl/ext_core.sv | 70 +++++++
 rtl/ext_pipe.sv | 84 ++++++++
 tb/tb_ext_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared extension op codes for the load/immediate extender
package ext_pkg;

  typedef logic [2:0] ext_op_t;

  localparam ext_op_t OP_IMM_SEXT = 3'd0;
  localparam ext_op_t OP_IMM_ZEXT = 3'd1;
  localparam ext_op_t OP_IMM_LUI  = 3'd2;
  localparam ext_op_t OP_LB       = 3'd3;
  localparam ext_op_t OP_LBU      = 3'd4;
  localparam ext_op_t OP_LH       = 3'd5;
  localparam ext_op_t OP_LHU      = 3'd6;
  localparam ext_op_t OP_LW       = 3'd7;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate extension and load-data extraction
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  ext_op_t                       in_op,
  input  logic [IMM_W-1:0]              in_imm,
  input  logic [DATA_W-1:0]             in_word,
  input  logic [$clog2(DATA_W/8)-1:0]   in_off,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_err
);

  localparam int OFF_W = $clog2(DATA_W/8);

  // Only 32- and 64-bit datapaths with a strictly narrower immediate are supported.
  if (!(DATA_W == 32 || DATA_W == 64) || IMM_W >= DATA_W) begin : g_bad_params
    $error("ext_core: DATA_W must be 32 or 64 and IMM_W must be less than DATA_W");
  end

  logic [15:0] w_imm16;
  logic [31:0] w_lui;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // The LUI field is always 16 bits wide regardless of IMM_W.
  assign w_imm16 = 16'(in_imm);
  assign w_lui   = {w_imm16, 16'h0000};

  // Little-endian lane select; the halfword index drops off[0] so it never
  // runs past the top of the word (odd offsets are flagged as misaligned).
  assign w_byte = in_word[{in_off, 3'b000} +: 8];
  assign w_half = in_word[{in_off[OFF_W-1:1], 4'b0000} +: 16];

  // Select the extension for the requested op; misaligned loads yield zero data with err set.
  always_comb begin
    out_data = '0;
    out_err  = 1'b0;
    case (in_op)
      OP_IMM_SEXT: out_data = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      OP_IMM_ZEXT: out_data = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      OP_IMM_LUI:  out_data = DATA_W'($signed(w_lui));
      OP_LB:       out_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      OP_LBU:      out_data = {{(DATA_W-8){1'b0}}, w_byte};
      OP_LH, OP_LHU: begin
        if (in_off[0]) begin
          out_err = 1'b1;
        end else if (in_op == OP_LH) begin
          out_data = {{(DATA_W-16){w_half[15]}}, w_half};
        end else begin
          out_data = {{(DATA_W-16){1'b0}}, w_half};
        end
      end
      OP_LW: begin
        if (in_off != '0) begin
          out_err = 1'b1;
        end else begin
          out_data = in_word;
        end
      end
      default: begin
        out_data = '0;
        out_err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered extender with a 2-entry skid buffer on the output
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  ext_op_t                       in_op,
  input  logic [IMM_W-1:0]              in_imm,
  input  logic [DATA_W-1:0]             in_word,
  input  logic [$clog2(DATA_W/8)-1:0]   in_off,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_err
);

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_err;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_tail_err;

  logic [DATA_W-1:0] w_new_data;
  logic              w_new_err;
  logic              w_push;
  logic              w_pop;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .in_op    (in_op),
    .in_imm   (in_imm),
    .in_word  (in_word),
    .in_off   (in_off),
    .out_data (w_new_data),
    .out_err  (w_new_err)
  );

  // Ready and valid depend only on the occupancy register, never on out_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head_data;
  assign out_err   = r_head_err;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Skid-buffer update: push fills head or tail, pop advances tail to head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_err  <= 1'b0;
      r_tail_data <= '0;
      r_tail_err  <= 1'b0;
    end else if (w_push && w_pop) begin
      // Only reachable at count 1: the new entry replaces the departing head.
      r_head_data <= w_new_data;
      r_head_err  <= w_new_err;
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_head_data <= w_new_data;
        r_head_err  <= w_new_err;
      end else begin
        r_tail_data <= w_new_data;
        r_tail_err  <= w_new_err;
      end
      r_count <= r_count + 2'd1;
    end else if (w_pop) begin
      if (r_count == 2'd2) begin
        r_head_data <= r_tail_data;
        r_head_err  <= r_tail_err;
      end
      r_count <= r_count - 2'd1;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe (32- and 64-bit builds)
module tb_ext_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  ext_op_t     in_op;
  logic [15:0] in_imm;
  logic [31:0] in_word;
  logic [1:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        w64_in_valid;
  logic        w64_in_ready;
  ext_op_t     w64_in_op;
  logic [15:0] w64_in_imm;
  logic [63:0] w64_in_word;
  logic [2:0]  w64_in_off;
  logic        w64_out_valid;
  logic        w64_out_ready;
  logic [63:0] w64_out_data;
  logic        w64_out_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ext_pipe #(.DATA_W(32), .IMM_W(16)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_word   (in_word),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  ext_pipe #(.DATA_W(64), .IMM_W(16)) u_dut64 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w64_in_valid),
    .in_ready  (w64_in_ready),
    .in_op     (w64_in_op),
    .in_imm    (w64_in_imm),
    .in_word   (w64_in_word),
    .in_off    (w64_in_off),
    .out_valid (w64_out_valid),
    .out_ready (w64_out_ready),
    .out_data  (w64_out_data),
    .out_err   (w64_out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ext_op_t op, input logic [15:0] imm, input logic [31:0] word,
                       input logic [1:0] off);
    in_op    = op;
    in_imm   = imm;
    in_word  = word;
    in_off   = off;
    in_valid = 1'b1;
  endtask

  // One op through the 32-bit pipe with out_ready high; result visible one cycle later.
  task automatic single(input string tag, input ext_op_t op, input logic [15:0] imm,
                        input logic [31:0] word, input logic [1:0] off,
                        input logic [31:0] exp_data, input logic exp_err);
    drive(op, imm, word, off);
    step();
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".data"},  64'(out_data),  64'(exp_data));
    check({tag, ".err"},   64'(out_err),   64'(exp_err));
  endtask

  task automatic single64(input string tag, input ext_op_t op, input logic [15:0] imm,
                          input logic [63:0] word, input logic [2:0] off,
                          input logic [63:0] exp_data, input logic exp_err);
    w64_in_op    = op;
    w64_in_imm   = imm;
    w64_in_word  = word;
    w64_in_off   = off;
    w64_in_valid = 1'b1;
    step();
    w64_in_valid = 1'b0;
    check({tag, ".valid"}, 64'(w64_out_valid), 64'd1);
    check({tag, ".data"},  w64_out_data,       exp_data);
    check({tag, ".err"},   64'(w64_out_err),   64'(exp_err));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_op = OP_IMM_SEXT; in_imm = '0; in_word = '0; in_off = '0;
    out_ready = 1'b1;
    w64_in_valid = 1'b0; w64_in_op = OP_IMM_SEXT; w64_in_imm = '0; w64_in_word = '0;
    w64_in_off = '0; w64_out_ready = 1'b1;

    step();
    step();
    reset = 1'b0;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.ready", 64'(in_ready),  64'd1);
    check("rst.data",  64'(out_data),  64'd0);
    check("rst.err",   64'(out_err),   64'd0);

    // Immediates and aligned loads, streamed one per cycle.
    single("sext",  OP_IMM_SEXT, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
    single("zext",  OP_IMM_ZEXT, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
    single("lui",   OP_IMM_LUI,  16'h1234, 32'h0, 2'd0, 32'h12340000, 1'b0);
    single("lui_neg", OP_IMM_LUI, 16'h8000, 32'h0, 2'd0, 32'h80000000, 1'b0);
    single("lb2",   OP_LB,  16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF, 1'b0);
    single("lb0",   OP_LB,  16'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
    single("lb1",   OP_LB,  16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
    single("lbu3",  OP_LBU, 16'h0, 32'h80FF7F01, 2'd3, 32'h00000080, 1'b0);
    single("lh2",   OP_LH,  16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
    single("lhu0",  OP_LHU, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
    single("lhu2",  OP_LHU, 16'h0, 32'h80FF7F01, 2'd2, 32'h000080FF, 1'b0);
    single("lw0",   OP_LW,  16'h0, 32'h80FF7F01, 2'd0, 32'h80FF7F01, 1'b0);

    // Misalignment.
    single("lh1_mis",  OP_LH,  16'h0, 32'h80FF7F01, 2'd1, 32'h0, 1'b1);
    single("lhu3_mis", OP_LHU, 16'h0, 32'h80FF7F01, 2'd3, 32'h0, 1'b1);
    single("lw2_mis",  OP_LW,  16'h0, 32'h80FF7F01, 2'd2, 32'h0, 1'b1);
    single("sext_off3", OP_IMM_SEXT, 16'h8001, 32'h0, 2'd3, 32'hFFFF8001, 1'b0);

    in_valid = 1'b0;
    step();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Back-pressure: A then B buffered, a third request must be refused.
    out_ready = 1'b0;
    drive(OP_LBU, 16'h0, 32'h000000A5, 2'd0);
    step();
    check("bp.a_valid", 64'(out_valid), 64'd1);
    check("bp.a_ready", 64'(in_ready),  64'd1);
    check("bp.a_data",  64'(out_data),  64'h000000A5);
    drive(OP_LHU, 16'h0, 32'h0000B00B, 2'd0);
    step();
    check("bp.full_ready", 64'(in_ready), 64'd0);
    check("bp.hold_data1", 64'(out_data), 64'h000000A5);
    drive(OP_IMM_ZEXT, 16'hCCCC, 32'h0, 2'd0);
    step();
    check("bp.hold_data2", 64'(out_data), 64'h000000A5);
    check("bp.hold_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp.b_data",  64'(out_data),  64'h0000B00B);
    check("bp.b_ready", 64'(in_ready),  64'd1);
    check("bp.b_valid", 64'(out_valid), 64'd1);
    step();
    check("bp.empty", 64'(out_valid), 64'd0);

    // Continuous stream: push and pop every cycle, occupancy stays at 1.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] imm_i;
      imm_i = 16'(i * 16'h1357 + 1);
      drive(OP_IMM_ZEXT, imm_i, 32'h0, 2'd0);
      step();
      check($sformatf("stream%0d.data", i),  64'(out_data), 64'(imm_i));
      check($sformatf("stream%0d.ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream.empty", 64'(out_valid), 64'd0);

    // Reset with both entries occupied, with a push and pop presented in that cycle.
    out_ready = 1'b0;
    drive(OP_IMM_ZEXT, 16'h1111, 32'h0, 2'd0);
    step();
    drive(OP_IMM_ZEXT, 16'h2222, 32'h0, 2'd0);
    step();
    check("rst2.full", 64'(in_ready), 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    drive(OP_IMM_ZEXT, 16'h3333, 32'h0, 2'd0);
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst2.valid", 64'(out_valid), 64'd0);
    check("rst2.data",  64'(out_data),  64'd0);
    check("rst2.ready", 64'(in_ready),  64'd1);
    step();
    check("rst2.still_empty", 64'(out_valid), 64'd0);

    // 64-bit build.
    single64("w64.lb7",   OP_LB,  16'h0, 64'h8000_0000_0000_0000, 3'd7,
             64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    single64("w64.lui",   OP_IMM_LUI, 16'h8000, 64'h0, 3'd0,
             64'hFFFF_FFFF_8000_0000, 1'b0);
    single64("w64.lhu6",  OP_LHU, 16'h0, 64'hBEEF_0000_0000_0000, 3'd6,
             64'h0000_0000_0000_BEEF, 1'b0);
    single64("w64.lw0",   OP_LW,  16'h0, 64'h0123_4567_89AB_CDEF, 3'd0,
             64'h0123_4567_89AB_CDEF, 1'b0);
    single64("w64.lw4",   OP_LW,  16'h0, 64'h0123_4567_89AB_CDEF, 3'd4,
             64'h0, 1'b1);
    single64("w64.sext",  OP_IMM_SEXT, 16'h8001, 64'h0, 3'd0,
             64'hFFFF_FFFF_FFFF_8001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
